// File: rtl/sr_register_bank.sv
// Multi-channel SR storage bank with selectable S=R=1 resolution, edge pulses and conflict statistics.
// Optional macro SR_BANK_INPUT_SYNC_EN adds 2-flop synchronisers on s, r and en.
module sr_register_bank #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      CONFLICT_MODE = 0,
  parameter int unsigned      CNT_W         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_stat,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             conflict_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] s_e;
  logic [WIDTH-1:0] r_e;
  logic             en_e;

`ifdef SR_BANK_INPUT_SYNC_EN
  logic [WIDTH-1:0] s_meta_q, s_sync_q;
  logic [WIDTH-1:0] r_meta_q, r_sync_q;
  logic             en_meta_q, en_sync_q;

  // Two-stage synchronisers for inputs arriving from another clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q  <= '0;
      s_sync_q  <= '0;
      r_meta_q  <= '0;
      r_sync_q  <= '0;
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
    end else begin
      s_meta_q  <= s;
      s_sync_q  <= s_meta_q;
      r_meta_q  <= r;
      r_sync_q  <= r_meta_q;
      en_meta_q <= en;
      en_sync_q <= en_meta_q;
    end
  end

  assign s_e  = s_sync_q;
  assign r_e  = r_sync_q;
  assign en_e = en_sync_q;
`else
  assign s_e  = s;
  assign r_e  = r;
  assign en_e = en;
`endif

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_q, any_d;
  logic [WIDTH-1:0] conflict_vec;
  logic [WIDTH-1:0] conf_val;
  logic [WIDTH-1:0] plain_val;

  // Next-state for storage bits, edge pulses and statistics
  always_comb begin
    conflict_vec = s_e & r_e & {WIDTH{en_e}};
    q_d          = q_q;
    conf_val     = q_q;
    plain_val    = (q_q & ~(r_e & ~s_e)) | (s_e & ~r_e);

    case (CONFLICT_MODE)
      1:       conf_val = '1;
      2:       conf_val = '0;
      3:       conf_val = ~q_q;
      default: conf_val = q_q;
    endcase

    if (en_e) begin
      q_d = (plain_val & ~conflict_vec) | (conf_val & conflict_vec);
    end

    rise_d   = ~q_q & q_d;
    fall_d   = q_q & ~q_d;
    any_d    = |conflict_vec;
    sticky_d = (clr_stat ? '0 : sticky_q) | conflict_vec;

    // Counter counts conflicting cycles; a same-cycle conflict survives a clear
    cnt_d = cnt_q;
    if (clr_stat) begin
      cnt_d = {{(CNT_W-1){1'b0}}, any_d};
    end else if (any_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q      <= RESET_VALUE;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
      any_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      any_q    <= any_d;
    end
  end

  assign q               = q_q;
  assign q_rise          = rise_q;
  assign q_fall          = fall_q;
  assign conflict_sticky = sticky_q;
  assign conflict_cnt    = cnt_q;
  assign conflict_any    = any_q;

endmodule
